// File: rtl/count_sequencer.sv
// count_sequencer: 8-bit sequenced counter with a programmable tick divider.
// A single FSM (IDLE/RUN/PAUSE/DONE) advances the count on divider ticks,
// either wrapping at a terminal value or halting there, and accepts
// clear/stop/start/step commands with fixed priority.
module count_sequencer #(
  parameter logic [25:0] RATE0 = 26'd1,
  parameter logic [25:0] RATE1 = 26'd5_000_000,
  parameter logic [25:0] RATE2 = 26'd25_000_000,
  parameter logic [25:0] RATE3 = 26'd50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       clear,
  input  logic       mode_oneshot,
  input  logic [1:0] rate_sel,
  input  logic [7:0] limit,
  output logic [7:0] count,
  output logic [1:0] state,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_STOP,
    CMD_START,
    CMD_STEP
  } cmd_e;

  state_e      state_q;
  logic [7:0]  count_q;
  logic [25:0] div_q;
  logic        done_q;
  logic        wrap_q;

  cmd_e        cmd;
  logic [25:0] reloadVal;
  logic [7:0]  countInc;
  logic        tick;

  // Reduce the four command inputs to the single highest-priority command.
  always_comb begin
    cmd = CMD_NONE;
    if (clear) begin
      cmd = CMD_CLEAR;
    end else if (stop) begin
      cmd = CMD_STOP;
    end else if (start) begin
      cmd = CMD_START;
    end else if (step) begin
      cmd = CMD_STEP;
    end
  end

  // Divider reload value is taken from the rate selected at reload time.
  always_comb begin
    reloadVal = RATE0 - 26'd1;
    case (rate_sel)
      2'd0:    reloadVal = RATE0 - 26'd1;
      2'd1:    reloadVal = RATE1 - 26'd1;
      2'd2:    reloadVal = RATE2 - 26'd1;
      default: reloadVal = RATE3 - 26'd1;
    endcase
  end

  assign countInc = count_q + 8'd1;
  assign tick     = (state_q == S_RUN) && (div_q == 26'd0);

  // Sequencer FSM: count, divider and the one-cycle done/wrap pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= 8'd0;
      div_q   <= 26'd0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (cmd == CMD_CLEAR) begin
        state_q <= S_IDLE;
        count_q <= 8'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cmd == CMD_START) begin
              state_q <= S_RUN;
              count_q <= 8'd0;
              div_q   <= reloadVal;
            end
          end
          S_RUN: begin
            if (cmd == CMD_STOP) begin
              state_q <= S_PAUSE;
            end else if (tick) begin
              div_q <= reloadVal;
              if (count_q == limit) begin
                if (mode_oneshot) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  count_q <= 8'd0;
                  wrap_q  <= 1'b1;
                end
              end else begin
                count_q <= countInc;
              end
            end else begin
              div_q <= div_q - 26'd1;
            end
          end
          S_PAUSE: begin
            if (cmd == CMD_START) begin
              state_q <= S_RUN;
              div_q   <= reloadVal;
            end else if (cmd == CMD_STEP) begin
              count_q <= countInc;
            end
          end
          S_DONE: begin
            if (cmd == CMD_START) begin
              state_q <= S_RUN;
              count_q <= 8'd0;
              div_q   <= reloadVal;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule
